// File: rtl/tree_pkg.sv
// Shared types and sizing for the message-hierarchy tree walker and its per-level table.
package tree_pkg;
    localparam int MAX_NODES_PER_LEVEL = 8;
    localparam int NUM_MSG_HIERARCHY   = 4;
    localparam int NODE_ID_W           = 16;
    localparam int FIELD_ID_W          = 8;
    localparam int LVL_W               = $clog2(NUM_MSG_HIERARCHY);
    localparam int SLOT_W              = $clog2(MAX_NODES_PER_LEVEL);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MAX_NODES_PER_LEVEL - 1);
    localparam logic [LVL_W-1:0]  LVL_TOP   = LVL_W'(NUM_MSG_HIERARCHY - 1);

    typedef struct packed {
        logic [NODE_ID_W-1:0]  node_id;
        logic [NODE_ID_W-1:0]  parent_node_id;
        logic [FIELD_ID_W-1:0] field_id;
    } tree_entry_t;

    typedef enum logic [1:0] {
        TOK_FIELD = 2'd0,
        TOK_OPEN  = 2'd1,
        TOK_CLOSE = 2'd2
    } tok_kind_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_MISS      = 2'd1,
        ERR_UNDERFLOW = 2'd2,
        ERR_OVERFLOW  = 2'd3
    } walk_err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_ERR  = 2'd3
    } walk_state_e;
endpackage

// File: rtl/tree_level_table.sv
// Flop-based tree table: one entry per (level, slot), single write port and one
// combinational read port.
module tree_level_table
    import tree_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [LVL_W-1:0]  wr_level,
    input  logic [SLOT_W-1:0] wr_slot,
    input  tree_entry_t       wr_entry,
    input  logic [LVL_W-1:0]  rd_level,
    input  logic [SLOT_W-1:0] rd_slot,
    output tree_entry_t       rd_entry
);
    tree_entry_t mem_q [NUM_MSG_HIERARCHY][MAX_NODES_PER_LEVEL];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int l = 0; l < NUM_MSG_HIERARCHY; l++) begin
                for (int s = 0; s < MAX_NODES_PER_LEVEL; s++) begin
                    mem_q[l][s] <= '0;
                end
            end
        end else if (we) begin
            mem_q[wr_level][wr_slot] <= wr_entry;
        end
    end

    assign rd_entry = mem_q[rd_level][rd_slot];
endmodule

// File: rtl/tree_walker.sv
// Resolves incoming field tokens to unique node ids by scanning the current tree
// level one slot per cycle, tracking nesting depth and the open-node path.
module tree_walker
    import tree_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  cfg_we,
    input  logic [LVL_W-1:0]      cfg_level,
    input  logic [SLOT_W-1:0]     cfg_slot,
    input  tree_entry_t           cfg_entry,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  tok_kind_e             in_kind,
    input  logic [FIELD_ID_W-1:0] in_field_id,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NODE_ID_W-1:0]  out_node_id,
    output logic [LVL_W-1:0]      out_level,
    output logic                  out_is_open,
    output logic                  err,
    output walk_err_e             err_code
);
    walk_state_e           state_q, state_d;
    logic [LVL_W-1:0]      level_q;
    logic [NODE_ID_W-1:0]  cur_node_q;
    logic [NODE_ID_W-1:0]  path_q [NUM_MSG_HIERARCHY];
    logic [SLOT_W-1:0]     slot_q;
    logic [FIELD_ID_W-1:0] fid_q;
    logic                  open_q;
    logic [NODE_ID_W-1:0]  node_q;
    logic [LVL_W-1:0]      node_lvl_q;
    logic                  node_open_q;
    logic                  err_q;
    walk_err_e             err_code_q;

    tree_entry_t           rd_entry;
    logic                  accept, cfg_ok, hit, scan_end, is_close, is_open_tok;
    walk_err_e             new_err;
    logic [LVL_W-1:0]      lvl_dec, lvl_dec2;

    tree_level_table u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (cfg_ok),
        .wr_level (cfg_level),
        .wr_slot  (cfg_slot),
        .wr_entry (cfg_entry),
        .rd_level (level_q),
        .rd_slot  (slot_q),
        .rd_entry (rd_entry)
    );

    assign lvl_dec  = level_q - LVL_W'(1);
    assign lvl_dec2 = level_q - LVL_W'(2);

    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        accept      = 1'b0;
        cfg_ok      = 1'b0;
        new_err     = ERR_NONE;
        is_close    = (in_kind == TOK_CLOSE);
        is_open_tok = (in_kind == TOK_OPEN);
        hit         = (rd_entry.node_id != '0) &&
                      (rd_entry.parent_node_id == cur_node_q) &&
                      (rd_entry.field_id == fid_q);
        // Slots fill contiguously, so the first empty slot ends the search.
        scan_end    = (rd_entry.node_id == '0) || (slot_q == SLOT_LAST);
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                cfg_ok   = cfg_we && !in_valid;
                if (in_valid) begin
                    if (is_close) begin
                        if (level_q == '0) new_err = ERR_UNDERFLOW;
                    end else if (is_open_tok && (level_q == LVL_TOP)) begin
                        new_err = ERR_OVERFLOW;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (hit)           state_d = ST_EMIT;
                else if (scan_end) new_err = ERR_MISS;
            end
            ST_EMIT: begin
                if (out_ready) state_d = ST_IDLE;
            end
            ST_ERR: begin
                in_ready = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (new_err != ERR_NONE) state_d = ST_ERR;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) state_q <= ST_IDLE;
        else               state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            level_q     <= '0;
            cur_node_q  <= '0;
            for (int i = 0; i < NUM_MSG_HIERARCHY; i++) path_q[i] <= '0;
            slot_q      <= '0;
            fid_q       <= '0;
            open_q      <= 1'b0;
            node_q      <= '0;
            node_lvl_q  <= '0;
            node_open_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            if ((state_q == ST_IDLE) && accept) begin
                if (is_close) begin
                    if (level_q != '0) begin
                        level_q    <= lvl_dec;
                        cur_node_q <= (lvl_dec == '0) ? '0 : path_q[lvl_dec2];
                    end
                end else begin
                    fid_q  <= in_field_id;
                    open_q <= is_open_tok;
                    slot_q <= '0;
                end
            end
            if (state_q == ST_SCAN) begin
                if (hit) begin
                    node_q      <= rd_entry.node_id;
                    node_lvl_q  <= level_q;
                    node_open_q <= open_q;
                end else begin
                    slot_q <= slot_q + SLOT_W'(1);
                end
            end
            // Descend only once the downstream stage has taken the OPEN node.
            if ((state_q == ST_EMIT) && out_ready && node_open_q) begin
                path_q[level_q] <= node_q;
                cur_node_q      <= node_q;
                level_q         <= level_q + LVL_W'(1);
            end
            if (new_err != ERR_NONE) begin
                err_q      <= 1'b1;
                err_code_q <= new_err;
            end
        end
    end

    assign out_valid   = (state_q == ST_EMIT);
    assign out_node_id = node_q;
    assign out_level   = node_lvl_q;
    assign out_is_open = node_open_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
endmodule

// File: tb/tb_tree_walker.sv
// Scoreboard bench for tree_walker: directed tokens push expected nodes, a monitor
// pops and compares on every output handshake.
module tb_tree_walker;
    import tree_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n, clr, cfg_we;
    logic [LVL_W-1:0]  cfg_level;
    logic [SLOT_W-1:0] cfg_slot;
    tree_entry_t       cfg_entry;
    logic              in_valid, in_ready;
    tok_kind_e         in_kind;
    logic [7:0]        in_field_id;
    logic              out_valid, out_ready;
    logic [15:0]       out_node_id;
    logic [1:0]        out_level;
    logic              out_is_open;
    logic              err;
    walk_err_e         err_code;

    typedef struct packed {
        logic [15:0] id;
        logic [1:0]  lvl;
        logic        op;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    tree_walker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .cfg_we      (cfg_we),
        .cfg_level   (cfg_level),
        .cfg_slot    (cfg_slot),
        .cfg_entry   (cfg_entry),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_kind     (in_kind),
        .in_field_id (in_field_id),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_node_id (out_node_id),
        .out_level   (out_level),
        .out_is_open (out_is_open),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got node %0d expected none", out_node_id);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_node_id", 32'(out_node_id), 32'(mon_e.id));
                chk("out_level", 32'(out_level), 32'(mon_e.lvl));
                chk("out_is_open", 32'(out_is_open), 32'(mon_e.op));
            end
        end
    end

    task automatic send(input tok_kind_e k, input logic [7:0] f);
        int n = 0;
        in_valid = 1'b1;
        in_kind = k;
        in_field_id = f;
        while (!in_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input logic [15:0] id, input logic [1:0] lvl, input logic op,
                              input int lat);
        exp_t e;
        int n = 0;
        e.id = id;
        e.lvl = lvl;
        e.op = op;
        sb_q.push_back(e);
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) chk("out_timeout", 32'(out_valid), 32'd1);
        else if (lat >= 0) chk("out_latency", 32'(cyc - acc_cyc), 32'(lat));
        n = 0;
        while (out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic expect_err(input walk_err_e code, input int lat);
        int n = 0;
        while (!err && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("err", 32'(err), 32'd1);
        chk("err_code", 32'(err_code), 32'(code));
        if (err) chk("err_latency", 32'(cyc - acc_cyc), 32'(lat));
    endtask

    task automatic cfg_write(input logic [1:0] l, input logic [2:0] s, input logic [15:0] id,
                             input logic [15:0] p, input logic [7:0] f);
        cfg_we = 1'b1;
        cfg_level = l;
        cfg_slot = s;
        cfg_entry = '{node_id: id, parent_node_id: p, field_id: f};
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_table();
        cfg_write(2'd0, 3'd0, 16'd5, 16'd0, 8'd1);
        cfg_write(2'd0, 3'd1, 16'd6, 16'd0, 8'd2);
        cfg_write(2'd1, 3'd0, 16'd9, 16'd6, 8'd1);
        cfg_write(2'd2, 3'd0, 16'd12, 16'd9, 8'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; clr = 1'b0; cfg_we = 1'b0; cfg_level = '0; cfg_slot = '0;
        cfg_entry = '0; in_valid = 1'b0; in_kind = TOK_FIELD; in_field_id = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_node", 32'(out_node_id), 32'd0);
        chk("rst_out_level", 32'(out_level), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'(ERR_NONE));

        load_table();

        // basic resolution, descend and rewind
        send(TOK_FIELD, 8'd2);  expect_out(16'd6, 2'd0, 1'b0, 2);
        send(TOK_OPEN, 8'd2);   expect_out(16'd6, 2'd0, 1'b1, 2);
        send(TOK_FIELD, 8'd1);  expect_out(16'd9, 2'd1, 1'b0, 1);
        send(TOK_CLOSE, 8'd0);
        idle(2);
        chk("close_no_err", 32'(err), 32'd0);
        send(TOK_FIELD, 8'd1);  expect_out(16'd5, 2'd0, 1'b0, 1);

        // miss, then tokens dropped while in error
        send(TOK_FIELD, 8'd7);  expect_err(ERR_MISS, 3);
        chk("err_in_ready", 32'(in_ready), 32'd1);
        send(TOK_FIELD, 8'd1);
        idle(4);
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_sticky_code", 32'(err_code), 32'(ERR_MISS));
        pulse_clr();
        chk("clr_err", 32'(err), 32'd0);

        // underflow
        send(TOK_CLOSE, 8'd0);  expect_err(ERR_UNDERFLOW, 0);
        pulse_clr();

        // nested path restore, then overflow
        send(TOK_OPEN, 8'd2);   expect_out(16'd6, 2'd0, 1'b1, 2);
        send(TOK_OPEN, 8'd1);   expect_out(16'd9, 2'd1, 1'b1, 1);
        send(TOK_CLOSE, 8'd0);
        send(TOK_FIELD, 8'd1);  expect_out(16'd9, 2'd1, 1'b0, 1);
        send(TOK_OPEN, 8'd1);   expect_out(16'd9, 2'd1, 1'b1, 1);
        send(TOK_OPEN, 8'd3);   expect_out(16'd12, 2'd2, 1'b1, 1);
        send(TOK_OPEN, 8'd5);   expect_err(ERR_OVERFLOW, 0);
        idle(3);
        pulse_clr();

        // backpressure in EMIT
        out_ready = 1'b0;
        send(TOK_FIELD, 8'd1);
        sb_q.push_back('{id: 16'd5, lvl: 2'd0, op: 1'b0});
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_node", 32'(out_node_id), 32'd5);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);

        // clr aborts an in-flight scan and rewinds to the root
        send(TOK_OPEN, 8'd2);   expect_out(16'd6, 2'd0, 1'b1, 2);
        send(TOK_FIELD, 8'd1);
        pulse_clr();
        chk("clr_scan_valid", 32'(out_valid), 32'd0);
        chk("clr_scan_ready", 32'(in_ready), 32'd1);
        idle(4);
        chk("clr_scan_err", 32'(err), 32'd0);
        send(TOK_FIELD, 8'd1);  expect_out(16'd5, 2'd0, 1'b0, 1);

        // reset mid-EMIT wipes the table
        out_ready = 1'b0;
        send(TOK_FIELD, 8'd1);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_node", 32'(out_node_id), 32'd0);
        out_ready = 1'b1;
        send(TOK_FIELD, 8'd1);  expect_err(ERR_MISS, 1);
        pulse_clr();

        // cfg writes ignored during SCAN, honoured in IDLE
        load_table();
        send(TOK_FIELD, 8'd2);
        cfg_write(2'd0, 3'd1, 16'd7, 16'd0, 8'd2);
        expect_out(16'd6, 2'd0, 1'b0, -1);
        send(TOK_FIELD, 8'd2);  expect_out(16'd6, 2'd0, 1'b0, 2);
        cfg_write(2'd0, 3'd1, 16'd7, 16'd0, 8'd2);
        send(TOK_FIELD, 8'd2);  expect_out(16'd7, 2'd0, 1'b0, 2);

        idle(3);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
